// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two write ports and a per-register
// busy scoreboard used for hazard detection.
// Optional feature: define REG_FILE_BYPASS_EN for same-cycle write-through
// forwarding on the read ports. The default build has no forwarding.

// One read port. Looks up data and busy for its address and, when BYPASS is
// set, forwards a same-cycle write. Write enables arrive already filtered
// for the zero register.
module reg_file_mp_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter bit BYPASS   = 1'b0
) (
    input  logic [ADDR_W-1:0]             ra,
    input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
    input  logic [DEPTH-1:0]              busy_bit,
    input  logic                          we0,
    input  logic [ADDR_W-1:0]             wa0,
    input  logic [DATA_W-1:0]             wd0,
    input  logic                          we1,
    input  logic [ADDR_W-1:0]             wa1,
    input  logic [DATA_W-1:0]             wd1,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic [DATA_W-1:0]             rd,
    output logic                          busy
);
    logic hit0, hit1, hit_rsv;

    assign hit0    = we0 && (wa0 == ra);
    assign hit1    = we1 && (wa1 == ra);
    assign hit_rsv = rsv_en && (rsv_addr == ra);

    // Lookup, optional forwarding (port 1 over port 0), then the zero-reg override.
    always_comb begin
        rd   = mem[ra];
        busy = busy_bit[ra];
        if (BYPASS) begin
            if (hit1)
                rd = wd1;
            else if (hit0)
                rd = wd0;
            // A same-cycle reserve keeps the register pending, so the
            // clear from the write is not forwarded in that case.
            if ((hit0 || hit1) && !hit_rsv)
                busy = 1'b0;
        end
        if (ZERO_REG != 0 && ra == '0) begin
            rd   = '0;
            busy = 1'b0;
        end
    end
endmodule

// Top level: storage, busy scoreboard and an array of read ports.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,   // legal range 1..4
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          busy
);
    localparam int DEPTH = 1 << ADDR_W;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy_bit;
    logic [DEPTH-1:0]             busy_nxt;
    logic                         we0_eff, we1_eff, rsv_eff;

    // With ZERO_REG set, anything aimed at register 0 is dropped here so the
    // storage, scoreboard and forwarding paths never see it.
    assign we0_eff = we0    && !(ZERO_REG != 0 && wa0 == '0);
    assign we1_eff = we1    && !(ZERO_REG != 0 && wa1 == '0);
    assign rsv_eff = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

    // Storage: reset loads each register with its own index; port 1 is
    // assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= DATA_W'(i);
        end else begin
            if (we0_eff)
                mem[wa0] <= wd0;
            if (we1_eff)
                mem[wa1] <= wd1;
        end
    end

    // Scoreboard next state: writes clear, reserve sets and takes priority.
    always_comb begin
        busy_nxt = busy_bit;
        if (we0_eff)
            busy_nxt[wa0] = 1'b0;
        if (we1_eff)
            busy_nxt[wa1] = 1'b0;
        if (rsv_eff)
            busy_nxt[rsv_addr] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_bit <= '0;
        else
            busy_bit <= busy_nxt;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        reg_file_mp_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .ra       (ra[k*ADDR_W +: ADDR_W]),
            .mem      (mem),
            .busy_bit (busy_bit),
            .we0      (we0_eff),
            .wa0      (wa0),
            .wd0      (wd0),
            .we1      (we1_eff),
            .wa1      (wa1),
            .wd1      (wd1),
            .rsv_en   (rsv_eff),
            .rsv_addr (rsv_addr),
            .rd       (rd[k*DATA_W +: DATA_W]),
            .busy     (busy[k])
        );
    end
endmodule
